// File: rtl/seg_pkg.sv
// Shared constants, segment encoding and converter state type for the
// multiplexed seven-segment display driver.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic {IDLE, CONV} conv_state_t;

    // Active-low {a..g} pattern for one hex digit.
    function automatic logic [6:0] hex2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// done, bcd_out and ovf are valid in the final CONV cycle so the caller can
// capture the result on the same edge that busy falls.
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int NDIG   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                ovf
);
    import seg_pkg::*;

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    conv_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sh;
    logic [BCD_W-1:0]   bcd;
    logic               ovf_acc;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_nxt;
    logic               carry;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is lost to the display, hence overflow.
    assign carry   = bcd_adj[BCD_W-1];
    assign bcd_nxt = {bcd_adj[BCD_W-2:0], sh[DATA_W-1]};

    assign busy    = (state == CONV);
    assign done    = busy && (cnt == LAST);
    assign bcd_out = bcd_nxt;
    assign ovf     = ovf_acc | carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            bcd     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CONV;
                        sh      <= bin_in;
                        bcd     <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                default: begin
                    sh      <= {sh[DATA_W-2:0], 1'b0};
                    bcd     <= bcd_nxt;
                    ovf_acc <= ovf_acc | carry;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_disp.sv
// Multiplexed common-anode seven-segment driver: hex or decimal display of a
// loaded value with leading-zero blanking, decimal points and overflow dashes.
module seg_scan_disp #(
    parameter int NDIG    = 4,
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  value,
    input  logic               load,
    input  logic               mode,
    input  logic               blank_lz,
    input  logic [NDIG-1:0]    dp_mask,
    output logic               busy,
    output logic [NDIG-1:0]    ssel,
    output logic [6:0]         sseg,
    output logic               dp
);
    import seg_pkg::*;

    localparam int BCD_W = 4 * NDIG;
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   idx;
    logic [BCD_W-1:0]   disp_q;
    logic               ovf_q;

    logic               start;
    logic               load_hex;
    logic [BCD_W-1:0]   hex_digits;
    logic               hex_ovf;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_ovf;

    assign load_hex   = load && !busy && !mode;
    assign start      = load && !busy && mode;
    assign hex_digits = BCD_W'(value);
    assign hex_ovf    = |(value >> BCD_W);

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .NDIG   (NDIG)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (value),
        .busy    (busy),
        .done    (conv_done),
        .bcd_out (conv_bcd),
        .ovf     (conv_ovf)
    );

    // Digit and overflow flag always change together so a scan never mixes
    // old and new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (load_hex) begin
            disp_q <= hex_digits;
            ovf_q  <= hex_ovf;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx     <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // lz[i] is set when digit i and every digit above it are zero.
    logic [NDIG-1:0] lz;
    logic            lz_acc;
    always_comb begin
        lz     = '0;
        lz_acc = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lz_acc = lz_acc & (disp_q[4*i +: 4] == 4'd0);
            lz[i]  = lz_acc;
        end
    end

    logic [3:0]      cur_digit;
    logic [6:0]      sseg_c;
    logic            dp_c;
    logic [NDIG-1:0] ssel_c;

    always_comb begin
        cur_digit = disp_q[4*idx +: 4];
        ssel_c    = ~(NDIG'(1) << idx);
        if (ovf_q) begin
            sseg_c = SEG_DASH;
            dp_c   = 1'b1;
        end else begin
            dp_c = ~dp_mask[idx];
            if (blank_lz && (idx != '0) && lz[idx]) begin
                sseg_c = SEG_BLANK;
            end else begin
                sseg_c = hex2seg(cur_digit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel <= ~NDIG'(1);
            sseg <= 7'b0000001;
            dp   <= 1'b1;
        end else begin
            ssel <= ssel_c;
            sseg <= sseg_c;
            dp   <= dp_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed bench for seg_scan_disp: a 4-digit instance for most scenarios and
// a 2-digit instance for hex overflow.
module tb_seg_scan_disp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        load2 = 1'b0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = '0;

    logic        busy, busy2;
    logic [3:0]  ssel;
    logic [1:0]  ssel2;
    logic [6:0]  sseg, sseg2;
    logic        dp, dp2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_disp #(.NDIG(4), .DATA_W(16), .PRESC_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .mode(mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy),
        .ssel(ssel), .sseg(sseg), .dp(dp)
    );

    seg_scan_disp #(.NDIG(2), .DATA_W(16), .PRESC_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load2), .mode(mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask[1:0]), .busy(busy2),
        .ssel(ssel2), .sseg(sseg2), .dp(dp2)
    );

    task automatic do_load(input bit alt, input logic [15:0] v, input logic m);
        @(negedge clk);
        value = v;
        mode  = m;
        if (alt) load2 = 1'b1;
        else     load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        load2 = 1'b0;
    endtask

    task automatic wait_digit(input bit alt, input int d, output bit ok);
        logic [3:0] want;
        want = 4'hF ^ (4'b0001 << d);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!alt && ssel == want) begin ok = 1'b1; break; end
            if (alt && ssel2 == want[1:0]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        dp_mask = 4'b0001;
        rst_n   = 1'b1;
        @(negedge clk);
        checks++;
        if (ssel !== 4'b1110 || sseg !== 7'b0000001 || dp !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ssel=%b sseg=%b dp=%b want 1110 0000001 0", ssel, sseg, dp);
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ssel !== 4'b1110 || sseg !== 7'b0000001 || dp !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ssel=%b sseg=%b dp=%b busy=%b want 1110 0000001 1 0",
                     ssel, sseg, dp, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hex();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        bit         ok;
        int         n;
        exp_seg = '{7'b0111000, 7'b0110000, 7'b0110000, 7'b1100000};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        blank_lz = 1'b0;
        dp_mask  = 4'b0100;
        do_load(1'b0, 16'hBEEF, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hex_busy: busy=%b want 0", busy);
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== exp_seg[d] || dp !== exp_dp[d] || busy !== 1'b0) begin
                errors++;
                $display("FAIL hex_digit%0d: found=%0d sseg=%b dp=%b busy=%b want %b %b 0",
                         d, ok, sseg, dp, busy, exp_seg[d], exp_dp[d]);
            end
            if (d == 1) begin
                n = 1;
                forever begin
                    @(negedge clk);
                    if (ssel != 4'b1101 || n >= 20) break;
                    n++;
                end
                checks++;
                if (n != 4) begin
                    errors++;
                    $display("FAIL hex_hold: digit held %0d cycles want 4", n);
                end
            end
        end
    endtask

    task automatic test_decimal();
        logic [6:0] exp_seg [4];
        bit         ok;
        int         n;
        exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        do_load(1'b0, 16'd1234, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin
                value = 16'd5555;
                load  = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL dec_busy_len: busy cycles=%0d want 16", n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dec_busy_after: busy=%b want 0", busy);
        end
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== exp_seg[d] || dp !== 1'b1) begin
                errors++;
                $display("FAIL dec_digit%0d: found=%0d sseg=%b dp=%b want %b 1",
                         d, ok, sseg, dp, exp_seg[d]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int n;
        blank_lz = 1'b1;
        dp_mask  = 4'b1111;
        do_load(1'b0, 16'd12345, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== 7'b1111110 || dp !== 1'b1) begin
                errors++;
                $display("FAIL ovf_dec_digit%0d: found=%0d sseg=%b dp=%b want 1111110 1",
                         d, ok, sseg, dp);
            end
        end
        do_load(1'b1, 16'h0ABC, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            wait_digit(1'b1, d, ok);
            checks++;
            if (!ok || sseg2 !== 7'b1111110 || dp2 !== 1'b1 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL ovf_hex_digit%0d: found=%0d sseg=%b dp=%b busy=%b want 1111110 1 0",
                         d, ok, sseg2, dp2, busy2);
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        int n;
        blank_lz = 1'b1;
        dp_mask  = 4'b0001;
        do_load(1'b0, 16'd7, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== ((d == 0) ? 7'b0001111 : 7'b1111111) || dp !== (d != 0)) begin
                errors++;
                $display("FAIL blank_on_digit%0d: found=%0d sseg=%b dp=%b", d, ok, sseg, dp);
            end
        end
        blank_lz = 1'b0;
        for (int d = 1; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== 7'b0000001 || dp !== 1'b1) begin
                errors++;
                $display("FAIL blank_off_digit%0d: found=%0d sseg=%b dp=%b want 0000001 1",
                         d, ok, sseg, dp);
            end
        end
    endtask

    task automatic test_abort();
        logic [6:0] exp_seg [4];
        bit         ok;
        int         n;
        exp_seg = '{7'b0010010, 7'b1001100, 7'b0000001, 7'b0000001};
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        do_load(1'b0, 16'd9999, 1'b1);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_mid: busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b want 0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== 7'b0000001 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_cleared_digit%0d: found=%0d sseg=%b busy=%b want 0000001 0",
                         d, ok, sseg, busy);
            end
        end
        do_load(1'b0, 16'd42, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            wait_digit(1'b0, d, ok);
            checks++;
            if (!ok || sseg !== exp_seg[d]) begin
                errors++;
                $display("FAIL abort_reload_digit%0d: found=%0d sseg=%b want %b",
                         d, ok, sseg, exp_seg[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_blanking();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
